// File: rtl/mux_scan.sv
// mux_scan: registered N-channel, W-bit multiplexer with manual selection and
// a dwell-timed automatic round-robin scan.
//
// y and ch_out are updated on the same edge from the same next-channel value,
// so ch_out always names the channel that produced the current y. Data is
// sampled every cycle. The en input only freezes the channel and the dwell
// count, so a frozen channel still streams fresh data.
//
// Changing dwell while a dwell period is in progress: the new value is
// compared against the running count straight away. If the count is already
// past the new dwell, there is no early step. The count runs on to
// 2**DWELL_W-1, rolls over to 0, and only steps once it matches dwell again.
// This is intentional and keeps the step condition a single equality compare.

module mux_scan #(
   parameter int WIDTH   = 1,
   parameter int CH      = 4,
   parameter int SELW    = $clog2(CH),
   parameter int DWELL_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CH*WIDTH-1:0]   in_bus,
   input  logic                  mode,
   input  logic [SELW-1:0]       sel,
   input  logic [DWELL_W-1:0]    dwell,
   input  logic                  en,
   output logic [WIDTH-1:0]      y,
   output logic [SELW-1:0]       ch_out,
   output logic                  wrap,
   output logic                  sel_err
);

   // Channel count with one extra bit, so that every sel value can be
   // range-checked (CH itself may not fit in SELW bits).
   localparam logic [SELW:0]   CH_EXT  = (SELW+1)'(CH);
   localparam logic [SELW-1:0] LAST_CH = SELW'(CH - 1);

   logic [SELW-1:0]    cur_ch_r;
   logic [DWELL_W-1:0] cnt_r;
   logic [WIDTH-1:0]   y_r;
   logic               wrap_r;
   logic               sel_err_r;

   logic [SELW-1:0]    next_ch_s;
   logic [DWELL_W-1:0] next_cnt_s;
   logic               next_wrap_s;
   logic               next_err_s;
   logic [WIDTH-1:0]   next_y_s;
   logic [WIDTH-1:0]   chan_s [CH];

   // Split the flat input bus into one entry per channel.
   for (genvar k = 0; k < CH; k++) begin : g_chan
      assign chan_s[k] = in_bus[k*WIDTH +: WIDTH];
   end

   // next_ch_s never exceeds CH-1, so the lookup always lands on a real channel.
   assign next_y_s = chan_s[next_ch_s];

   // Next channel, dwell count and event pulses for the coming edge.
   always_comb begin
      next_ch_s   = cur_ch_r;
      next_cnt_s  = cnt_r;
      next_wrap_s = 1'b0;
      next_err_s  = 1'b0;
      if (!en) begin
         // Frozen: channel and count hold, and no events are reported.
         next_ch_s  = cur_ch_r;
         next_cnt_s = cnt_r;
      end else if (!mode) begin
         // Manual: count is kept at zero, so a later switch to auto
         // starts a full dwell from the current channel.
         next_cnt_s = {DWELL_W{1'b0}};
         if ({1'b0, sel} < CH_EXT) begin
            next_ch_s = sel;
         end else begin
            next_ch_s  = cur_ch_r;
            next_err_s = 1'b1;
         end
      end else begin
         // Auto: hold each channel for dwell+1 cycles, then step.
         if (cnt_r == dwell) begin
            next_cnt_s = {DWELL_W{1'b0}};
            if (cur_ch_r == LAST_CH) begin
               next_ch_s   = {SELW{1'b0}};
               next_wrap_s = 1'b1;
            end else begin
               next_ch_s   = cur_ch_r + SELW'(1);
               next_wrap_s = 1'b0;
            end
         end else begin
            next_cnt_s = cnt_r + DWELL_W'(1);
            next_ch_s  = cur_ch_r;
         end
      end
   end

   // State and output registers. Reset clears everything asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_ch_r  <= {SELW{1'b0}};
         cnt_r     <= {DWELL_W{1'b0}};
         y_r       <= {WIDTH{1'b0}};
         wrap_r    <= 1'b0;
         sel_err_r <= 1'b0;
      end else begin
         cur_ch_r  <= next_ch_s;
         cnt_r     <= next_cnt_s;
         y_r       <= next_y_s;
         wrap_r    <= next_wrap_s;
         sel_err_r <= next_err_s;
      end
   end

   assign y       = y_r;
   assign ch_out  = cur_ch_r;
   assign wrap    = wrap_r;
   assign sel_err = sel_err_r;

endmodule
